secuenciador_alu: RTL
=====================

# secuenciador_alu

Sequential front/back stage wrapped around the combinational ALU on the lab board. It collects operand A, operand B and the operation code from one shared switch bus via successive presses of a single load button, drives them to the ALU, and after one settle cycle registers the ALU result and N/Z/C/V flags for display. The block is a pure sequencer: it contains no arithmetic.

## Interface
Parameters:
- ancho, 3, MSB index of data paths (data width ancho+1, same convention as the ALU); ancho >= 3 required.

Ports:
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- entrada  in  ancho+1  switch bus; carries A, B or opcode (bits [3:0]) depending on state.
- cargar  in  1  raw, asynchronous load button (level).
- resultadoALU  in  ancho+1  ALU result.
- N, Z, C, V  in  1 each  ALU flags.
- operandoA  out  ancho+1  registered, to ALU.
- operandoB  out  ancho+1  registered, to ALU.
- seleccion  out  4  registered opcode, to ALU.
- resultado  out  ancho+1  captured result.
- banderas  out  4  captured flags {N,Z,C,V}.
- valido  out  1  high while resultado/banderas hold a fresh capture.
- error  out  1  sticky: last opcode press was rejected.
- estado  out  3  current FSM state (for LEDs).

## Operation
- Button conditioning: 3-flop chain s0<=cargar, s1<=s0, s2<=s1; pulso = s1 & ~s2. One pulso per press regardless of hold length. No debounce filter; bounce can produce extra pulses (accepted lab limitation).
- FSM states/encoding: ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, EJECUTA=3, MUESTRA=4. Codes 5-7 unreachable; if reached, next state is ESPERA_A.
- ESPERA_A + pulso: operandoA<=entrada, valido<=0, -> ESPERA_B.
- ESPERA_B + pulso: operandoB<=entrada, -> ESPERA_OP.
- ESPERA_OP + pulso: if entrada[3:0] <= 9: seleccion<=entrada[3:0], error<=0, -> EJECUTA. If 10-15: seleccion unchanged, error<=1, stay in ESPERA_OP.
- EJECUTA: unconditional, one cycle; at its closing edge resultado<=resultadoALU, banderas<={N,Z,C,V}, valido<=1, -> MUESTRA. Pulsos arriving in EJECUTA are dropped.
- MUESTRA + pulso: operandoA<=entrada, valido<=0, -> ESPERA_B. operandoB, seleccion, resultado and banderas hold their values until overwritten.
- Without pulso every state except EJECUTA holds.
- Widths: entrada, operands and resultado are all ancho+1; no extension or truncation. Opcode uses only entrada[3:0].

## Timing
- Reset (rst high at a clock edge): estado=ESPERA_A; operandoA, operandoB, seleccion, resultado, banderas = 0; valido=0; error=0; s0,s1,s2 = 1. A button held through reset therefore produces no pulso until released and pressed again.
- Reset mid-operation (any state) has the same effect; a pending capture in EJECUTA is discarded.
- Press latency: cargar first sampled high at edge k -> pulso high during cycle k+1..k+2 -> register load and state change at edge k+2. entrada is sampled at edge k+2 and must be stable then.
- Op press to valido: opcode captured at edge k+2, EJECUTA for one cycle, resultado/banderas/valido updated at edge k+3.
- The ALU must settle within one clock from operand/opcode register outputs.
- Simultaneous rst and pulso: rst wins.

## Test plan
- Reset with cargar held high, release rst -> estado=0, all outputs 0; no state change until cargar goes low and then high again.
- ancho=3, real ALU: press with entrada=5, then 3, then 0 (suma) -> operandoA=5, operandoB=3, seleccion=0; one cycle after the opcode load, resultado=4'b1000, banderas[3](N)=1, Z=0, valido=1, estado=4.
- ALU stub drives resultadoALU=4'hA, flags=4'b1001: full sequence -> resultado=4'hA, banderas=4'b1001 captured exactly at edge k+3 after the opcode press; cycle-exact check of k+2/k+3.
- In ESPERA_OP press entrada=4'hC -> error=1, estado stays 2, seleccion unchanged; press entrada=4'h2 -> error=0, proceeds to EJECUTA.
- In MUESTRA press entrada=7 -> operandoA=7, valido=0, estado=1, resultado keeps its previous value; cargar held 50 cycles gives exactly one load.
- Assert rst while in ESPERA_OP after A=6, B=2 loaded -> all outputs 0, estado=0 on the next cycle.

Source files
------------

// File: rtl/secuenciador_alu.sv
// Load/execute sequencer around the lab ALU: gathers A, B and opcode from one
// switch bus on successive button presses, then latches result and flags.
module secuenciador_alu #(
    parameter int ancho = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ancho:0]   entrada,
    input  logic             cargar,
    input  logic [ancho:0]   resultadoALU,
    input  logic             N,
    input  logic             Z,
    input  logic             C,
    input  logic             V,
    output logic [ancho:0]   operandoA,
    output logic [ancho:0]   operandoB,
    output logic [3:0]       seleccion,
    output logic [ancho:0]   resultado,
    output logic [3:0]       banderas,
    output logic             valido,
    output logic             error,
    output logic [2:0]       estado
);

    typedef enum logic [2:0] {
        ESPERA_A  = 3'd0,
        ESPERA_B  = 3'd1,
        ESPERA_OP = 3'd2,
        EJECUTA   = 3'd3,
        MUESTRA   = 3'd4
    } estadoT;

    estadoT est;
    logic   s0, s1, s2;
    logic   pulso;

    // Chain resets to ones so a button held through reset yields no pulse.
    assign pulso  = s1 & ~s2;
    assign estado = est;

    always_ff @(posedge clk) begin
        if (rst) begin
            est       <= ESPERA_A;
            s0        <= 1'b1;
            s1        <= 1'b1;
            s2        <= 1'b1;
            operandoA <= '0;
            operandoB <= '0;
            seleccion <= '0;
            resultado <= '0;
            banderas  <= '0;
            valido    <= 1'b0;
            error     <= 1'b0;
        end else begin
            s0 <= cargar;
            s1 <= s0;
            s2 <= s1;
            case (est)
                ESPERA_A, MUESTRA: if (pulso) begin
                    operandoA <= entrada;
                    valido    <= 1'b0;
                    est       <= ESPERA_B;
                end
                ESPERA_B: if (pulso) begin
                    operandoB <= entrada;
                    est       <= ESPERA_OP;
                end
                ESPERA_OP: if (pulso) begin
                    if (entrada[3:0] <= 4'd9) begin
                        seleccion <= entrada[3:0];
                        error     <= 1'b0;
                        est       <= EJECUTA;
                    end else begin
                        error <= 1'b1;
                    end
                end
                // ALU has had one full cycle to settle on the new operands
                EJECUTA: begin
                    resultado <= resultadoALU;
                    banderas  <= {N, Z, C, V};
                    valido    <= 1'b1;
                    est       <= MUESTRA;
                end
                default: est <= ESPERA_A;
            endcase
        end
    end

endmodule
